qspi_rcache: RTL

QSPI_RCACHE -- requirements
Module: qspi_rcache

---
 rtl/qspi_pkg.sv | 30 +++
 rtl/qspi_rcache_if.sv | 34 +++
 rtl/qspi_rcache_ram.sv | 37 +++
 rtl/qspi_rcache.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/qspi_pkg.sv
// Shared types and widths for the QSPI read cache: FSM encoding, bus widths, index/tag sizing.
// Pure definitions; no logic, no latency, no flow control.
package qspi_pkg;

  localparam int ADDR_W      = 23;
  localparam int DATA_W      = 32;
  localparam int STRB_W      = 4;
  localparam int CNT_W       = 16;
  localparam int ENTRIES_DEF = 16;
  localparam int INDEX_W     = $clog2(ENTRIES_DEF);
  localparam int TAG_W       = ADDR_W - INDEX_W;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_MEM_REQ,
    ST_MEM_RELEASE,
    ST_RESP,
    ST_GAP
  } state_e;

  function automatic int index_w(input int entries);
    return $clog2(entries);
  endfunction

  function automatic int tag_w(input int entries);
    return ADDR_W - $clog2(entries);
  endfunction

endpackage

// File: rtl/qspi_rcache_if.sv
// CPU-side request bus, memory-side qqspi port, flush and performance counters bundled together.
// slave = cache view, master = CPU/memory-model view.
interface qspi_rcache_if;
  import qspi_pkg::*;

  logic              valid;
  logic              ready;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;
  logic [DATA_W-1:0] rdata;

  logic              mem_valid;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [STRB_W-1:0] mem_wstrb;
  logic [DATA_W-1:0] mem_rdata;

  logic              flush;
  logic [CNT_W-1:0]  hit_cnt;
  logic [CNT_W-1:0]  miss_cnt;

  modport slave (
    input  valid, addr, wdata, wstrb, flush, mem_ready, mem_rdata,
    output ready, rdata, mem_valid, mem_addr, mem_wdata, mem_wstrb, hit_cnt, miss_cnt
  );

  modport master (
    output valid, addr, wdata, wstrb, flush, mem_ready, mem_rdata,
    input  ready, rdata, mem_valid, mem_addr, mem_wdata, mem_wstrb, hit_cnt, miss_cnt
  );

endinterface

// File: rtl/qspi_rcache_ram.sv
// Line data + tag storage, one synchronous read port and one write port, no reset (RAM-inferable).
// Read data appears one cycle after rd_idx; writes take effect on the clock edge.
module qspi_rcache_ram
  import qspi_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = 4,
  parameter int TG_W    = 19
) (
  input  logic              clk,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [DATA_W-1:0] rd_dat,
  output logic [TG_W-1:0]   rd_tag,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [DATA_W-1:0] wr_dat,
  input  logic [TG_W-1:0]   wr_tag
);

  logic [DATA_W-1:0] dat_mem [ENTRIES];
  logic [TG_W-1:0]   tag_mem [ENTRIES];
  logic [DATA_W-1:0] rd_dat_q;
  logic [TG_W-1:0]   rd_tag_q;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      dat_mem[wr_idx] <= wr_dat;
      tag_mem[wr_idx] <= wr_tag;
    end
    rd_dat_q <= dat_mem[rd_idx];
    rd_tag_q <= tag_mem[rd_idx];
  end

  assign rd_dat = rd_dat_q;
  assign rd_tag = rd_tag_q;

endmodule

// File: rtl/qspi_rcache.sv
// Direct-mapped one-word read cache in front of a qqspi controller; write-through, no write-allocate.
// Read hit completes 2 cycles after valid; misses/writes wait on the mem_valid/mem_ready handshake.
module qspi_rcache
  import qspi_pkg::*;
#(
  parameter int ENTRIES = 16
) (
  input  logic          clk,
  input  logic          reset,
  qspi_rcache_if.slave  bus
);

  localparam int IW = index_w(ENTRIES);
  localparam int TW = tag_w(ENTRIES);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [CNT_W-1:0]    hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0]    miss_cnt_q, miss_cnt_d;
  logic [ENTRIES-1:0]  line_vld_q, line_vld_d;

  logic [IW-1:0]       idx_q;
  logic [TW-1:0]       tag_q;
  logic [IW-1:0]       rd_idx;
  logic [DATA_W-1:0]   rd_dat;
  logic [TW-1:0]       rd_tag;
  logic                wr_en;
  logic [DATA_W-1:0]   wr_dat;
  logic [DATA_W-1:0]   merged_dat;
  logic                line_hit;
  logic                is_read;

  assign idx_q   = addr_q[IW-1:0];
  assign tag_q   = addr_q[ADDR_W-1:IW];
  assign is_read = (wstrb_q == '0);

  // In IDLE the array is read at the incoming index so the line is ready by LOOKUP;
  // afterwards it keeps reading the latched index so later states see current contents.
  assign rd_idx   = (state_q == ST_IDLE) ? bus.addr[IW-1:0] : idx_q;
  assign line_hit = line_vld_q[idx_q] && (rd_tag == tag_q);

  qspi_rcache_ram #(
    .ENTRIES (ENTRIES),
    .IDX_W   (IW),
    .TG_W    (TW)
  ) u_ram (
    .clk    (clk),
    .rd_idx (rd_idx),
    .rd_dat (rd_dat),
    .rd_tag (rd_tag),
    .wr_en  (wr_en),
    .wr_idx (idx_q),
    .wr_dat (wr_dat),
    .wr_tag (tag_q)
  );

  always_comb begin
    merged_dat = rd_dat;
    for (int b = 0; b < STRB_W; b++) begin
      if (wstrb_q[b]) merged_dat[b*8 +: 8] = wdata_q[b*8 +: 8];
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    rdata_d    = rdata_q;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    line_vld_d = line_vld_q;
    wr_en      = 1'b0;
    wr_dat     = bus.mem_rdata;

    case (state_q)
      ST_IDLE: begin
        if (bus.valid) begin
          addr_d  = bus.addr;
          wdata_d = bus.wdata;
          wstrb_d = bus.wstrb;
          state_d = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        if (is_read && line_hit) begin
          rdata_d = rd_dat;
          if (hit_cnt_q != {CNT_W{1'b1}}) hit_cnt_d = hit_cnt_q + 1'b1;
          state_d = ST_RESP;
        end else begin
          if (is_read && miss_cnt_q != {CNT_W{1'b1}}) miss_cnt_d = miss_cnt_q + 1'b1;
          state_d = ST_MEM_REQ;
        end
      end
      ST_MEM_REQ: begin
        if (bus.mem_ready) begin
          if (is_read) begin
            rdata_d            = bus.mem_rdata;
            wr_en              = 1'b1;
            wr_dat             = bus.mem_rdata;
            line_vld_d[idx_q]  = 1'b1;
          end else if (line_hit) begin
            wr_en  = 1'b1;
            wr_dat = merged_dat;
          end
          state_d = ST_MEM_RELEASE;
        end
      end
      ST_MEM_RELEASE: begin
        if (!bus.mem_ready) state_d = ST_RESP;
      end
      ST_RESP: state_d = ST_GAP;
      ST_GAP:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Flush wins over a same-cycle fill: the returned word still goes to the CPU.
    if (bus.flush) line_vld_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      rdata_q    <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      line_vld_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      rdata_q    <= rdata_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      line_vld_q <= line_vld_d;
    end
  end

  assign bus.ready     = (state_q == ST_RESP);
  assign bus.rdata     = rdata_q;
  assign bus.mem_valid = (state_q == ST_MEM_REQ);
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_wstrb = wstrb_q;
  assign bus.hit_cnt   = hit_cnt_q;
  assign bus.miss_cnt  = miss_cnt_q;

endmodule
